tdm_demux4: RTL

Four-channel time-division demultiplexer: the receive end of the 4:1 slot-multiplexed link. It takes a single W-bit beat stream tagged with start-of-frame and steers beats 0..3 of each frame to four lane registers. A completed frame is published atomically with a one-cycle valid pulse. Malformed frames are flagged, and beats arriving outside a frame are counted. It sits between the link input and the per-lane consumers.

---
 rtl/tdm_demux4.sv | 118 +++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//   Receive end of a 4:1 slot-multiplexed link. Beats tagged with start-of-frame
//   are steered into slots 0..3. A completed frame is published atomically to
//   four lane registers with a one-cycle out_valid pulse. An early SOF aborts
//   the frame in progress and raises frame_err. Beats that arrive while no
//   frame is open are counted in a saturating drop counter.
//
// Ports
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   in_valid             beat present this cycle
//   in_sof               beat is slot 0 of a frame (qualified by in_valid)
//   in_data   [W-1:0]    beat payload
//   out_data0..3 [W-1:0] lane registers, slots 0..3 of the last good frame
//   out_valid            one-cycle pulse when out_data0..3 are updated
//   frame_err            one-cycle pulse when a partial frame is aborted
//   drop_cnt [DCNT_W-1:0] saturating count of beats discarded while hunting
// -----------------------------------------------------------------------------
module tdm_demux4 #(
  parameter int W      = 8,
  parameter int DCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [W-1:0]      out_data0,
  output logic [W-1:0]      out_data1,
  output logic [W-1:0]      out_data2,
  output logic [W-1:0]      out_data3,
  output logic              out_valid,
  output logic              frame_err,
  output logic [DCNT_W-1:0] drop_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t       state;
  logic [1:0]   slot;

  // Slots 0..2 are staged here; the slot-3 beat goes straight to out_data3 so
  // the whole frame lands in the lane registers on the same edge.
  logic [W-1:0] shadow [0:2];

  // Control path and all outputs. Pulses default low every cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot      <= 2'd0;
      out_data0 <= '0;
      out_data1 <= '0;
      out_data2 <= '0;
      out_data3 <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (in_valid) begin
        unique case (state)
          HUNT: begin
            if (in_sof) begin
              slot  <= 2'd1;
              state <= RECV;
            end else if (drop_cnt != {DCNT_W{1'b1}}) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
          end
          RECV: begin
            if (in_sof) begin
              // Abort the partial frame; this SOF opens the next one.
              frame_err <= 1'b1;
              slot      <= 2'd1;
            end else if (slot == 2'd3) begin
              out_data0 <= shadow[0];
              out_data1 <= shadow[1];
              out_data2 <= shadow[2];
              out_data3 <= in_data;
              out_valid <= 1'b1;
              slot      <= 2'd0;
              state     <= HUNT;
            end else begin
              slot <= slot + 2'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Shadow staging registers.
  // NOTE: the shadow array is deliberately not reset: it is never observed
  // before being written by a fresh frame, and leaving it out of the reset
  // tree keeps it plain storage.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      if (in_sof) begin
        shadow[0] <= in_data;
      end else if (state == RECV) begin
        case (slot)
          2'd1:    shadow[1] <= in_data;
          2'd2:    shadow[2] <= in_data;
          default: ;
        endcase
      end
    end
  end

endmodule
